eth_spi_bridge: RTL

Host-side counterpart of the PC Card NE2000 core's frame interface. It decodes ethernet commands from the IO controller's SPI link and drives the core's `tx_begin`/`tx_strobe`, `rx_begin`/`rx_strobe` and `mac_begin`/`mac_strobe` handshakes. It also returns `tx_byte` and the 32-bit status word to the controller. It sits beside the minimig user_io SPI client, in the `clk` domain of the NE2000 core.

---
 rtl/eth_spi_bridge_pkg.sv | 56 +++++
 rtl/eth_spi_bridge_spi_byte_slave.sv | 94 +++++++++
 rtl/eth_spi_bridge.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_spi_bridge_pkg.sv
// eth_spi_bridge_pkg: command codes, FSM state encoding, strobe generator
// encodings and the NE2000 status constants shared with the core.
`timescale 1ns/1ps
package eth_spi_bridge_pkg;

  localparam logic [7:0] CMD_STATUS  = 8'h30;
  localparam logic [7:0] CMD_MAC     = 8'h31;
  localparam logic [7:0] CMD_TXREAD  = 8'h32;
  localparam logic [7:0] CMD_RXWRITE = 8'h33;

  // Status byte values understood by the NE2000 core
  localparam logic [7:0] ETH_STAT_NOTX   = 8'hFE;
  localparam logic [7:0] ETH_STAT_TXPEND = 8'hA5;
  localparam logic [7:0] ETH_STAT_ID     = 8'h12;

  // Number of MAC address bytes that are forwarded to the core
  localparam logic [2:0] MAC_LEN = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_STAT = 3'd2,
    ST_MAC  = 3'd3,
    ST_TX   = 3'd4,
    ST_RX   = 3'd5,
    ST_SKIP = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    SG_IDLE  = 2'd0,
    SG_SETUP = 2'd1,
    SG_HIGH  = 2'd2,
    SG_LOW   = 2'd3
  } sg_phase_e;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_TX   = 2'd1,
    TGT_RX   = 2'd2,
    TGT_MAC  = 2'd3
  } sg_tgt_e;

  // Pick byte idx of the status word, MSB first; anything past the 4th reads 0
  function automatic logic [7:0] status_byte(input logic [31:0] word, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = word[31:24];
      3'd1:    b = word[23:16];
      3'd2:    b = word[15:8];
      3'd3:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/eth_spi_bridge_spi_byte_slave.sv
// spi_byte_slave: SPI mode 0 byte-level slave running in the clk domain.
// Synchronizes SCK/SS/MOSI, counts bits, shifts MOSI in and MISO out, and
// offers a byte_done pulse plus a load port for the next outgoing byte.
`timescale 1ns/1ps
module spi_byte_slave
  import eth_spi_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sck,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       ss_fall,
  output logic       ss_rise,
  output logic       byte_done,
  output logic [7:0] rx_data
);

  logic [2:0] sck_sync_r;
  logic [2:0] ss_sync_r;
  logic [1:0] mosi_sync_r;
  logic [2:0] bit_cnt_r;
  logic [6:0] rx_shift_r;
  logic [7:0] rx_data_r;
  logic [7:0] tx_shift_r;
  logic       byte_done_r;
  logic       sck_rise_s;
  logic       sck_fall_s;
  logic       ss_active_s;

  // Two-flop synchronizers; the third SCK/SS stage is the previous value for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_r  <= 3'b000;
      ss_sync_r   <= 3'b111;
      mosi_sync_r <= 2'b00;
    end else begin
      sck_sync_r  <= {sck_sync_r[1:0], spi_sck};
      ss_sync_r   <= {ss_sync_r[1:0], spi_ss_n};
      mosi_sync_r <= {mosi_sync_r[0], spi_mosi};
    end
  end

  assign sck_rise_s  = sck_sync_r[1] & ~sck_sync_r[2];
  assign sck_fall_s  = ~sck_sync_r[1] & sck_sync_r[2];
  assign ss_active_s = ~ss_sync_r[1];
  assign ss_fall     = ~ss_sync_r[1] & ss_sync_r[2];
  assign ss_rise     = ss_sync_r[1] & ~ss_sync_r[2];

  // Sample MOSI on SCK rise; the 8th bit completes a byte and the counter wraps to 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_r   <= 3'd0;
      rx_shift_r  <= 7'd0;
      rx_data_r   <= 8'h00;
      byte_done_r <= 1'b0;
    end else begin
      byte_done_r <= 1'b0;
      if (!ss_active_s) begin
        bit_cnt_r <= 3'd0;
      end else if (sck_rise_s) begin
        rx_shift_r <= {rx_shift_r[5:0], mosi_sync_r[1]};
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          rx_data_r   <= {rx_shift_r, mosi_sync_r[1]};
          byte_done_r <= 1'b1;
        end
      end
    end
  end

  // MISO shifter: a load presents its MSB at once; the falling edge that follows
  // the 8th rising edge (counter back at 0) must not shift, so a byte loaded
  // between bytes survives until the next byte starts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift_r <= 8'h00;
    end else if (load) begin
      tx_shift_r <= load_data;
    end else if (ss_fall) begin
      tx_shift_r <= 8'h00;
    end else if (ss_active_s && sck_fall_s && (bit_cnt_r != 3'd0)) begin
      tx_shift_r <= {tx_shift_r[6:0], 1'b0};
    end
  end

  assign spi_miso  = ~spi_ss_n & tx_shift_r[7];
  assign byte_done = byte_done_r;
  assign rx_data   = rx_data_r;

endmodule

// File: rtl/eth_spi_bridge.sv
// eth_spi_bridge: decodes IO-controller SPI commands and drives the NE2000
// core's tx/rx/mac begin+strobe handshakes; returns status and tx bytes.
// Optional feature macro: ETH_SPI_BRIDGE_IRQ_EN adds the eth_irq output.
`timescale 1ns/1ps
module eth_spi_bridge
  import eth_spi_bridge_pkg::*;
#(
  parameter int STROBE_W = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_sck,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [31:0] status,
  output logic        tx_begin,
  output logic        tx_strobe,
  input  logic [7:0]  tx_byte,
  output logic        rx_begin,
  output logic        rx_strobe,
  output logic [7:0]  rx_byte,
  output logic        mac_begin,
  output logic        mac_strobe,
  output logic [7:0]  mac_byte
`ifdef ETH_SPI_BRIDGE_IRQ_EN
  ,
  output logic        eth_irq
`endif
);

  localparam logic [7:0] PHASE_LAST = 8'(STROBE_W - 1);

  state_e     state_r, next_state_s;
  logic       ss_fall_s, ss_rise_s, byte_done_s;
  logic [7:0] rx_data_s;
  logic       byte_vld_r;
  logic [7:0] byte_r;
  logic       load_r;
  logic [7:0] load_data_r;
  logic [31:0] status_lat_r;
  logic [2:0] stat_idx_r;
  logic [2:0] mac_cnt_r;
  logic [7:0] mac_bcnt_r;
  logic       tx_begin_r, rx_begin_r, mac_begin_r;
  logic       decode_s, payload_s, tx_load_s;
  logic       req_s, queue_s, start_s;
  sg_tgt_e    req_tgt_s, start_tgt_s;
  logic [7:0] req_byte_s, start_byte_s;
  sg_phase_e  sg_phase_r;
  logic [7:0] sg_cnt_r;
  sg_tgt_e    sg_tgt_r;
  logic       pend_vld_r;
  sg_tgt_e    pend_tgt_r;
  logic [7:0] pend_byte_r;
  logic       tx_strobe_r, rx_strobe_r, mac_strobe_r;
  logic [7:0] rx_byte_r, mac_byte_r;

  spi_byte_slave u_slave (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_sck   (spi_sck),
    .spi_ss_n  (spi_ss_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .load      (load_r),
    .load_data (load_data_r),
    .ss_fall   (ss_fall_s),
    .ss_rise   (ss_rise_s),
    .byte_done (byte_done_s),
    .rx_data   (rx_data_s)
  );

  // Register each completed byte once more so command decode lands 3 clk after the 8th SCK rise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_vld_r <= 1'b0;
      byte_r     <= 8'h00;
    end else begin
      byte_vld_r <= byte_done_s;
      if (byte_done_s) begin
        byte_r <= rx_data_s;
      end
    end
  end

  assign decode_s  = (state_r == ST_CMD) && byte_vld_r && !ss_rise_s;
  assign payload_s = byte_vld_r && !ss_rise_s &&
                     (state_r != ST_IDLE) && (state_r != ST_CMD);

  // Command FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Command FSM next state: SS rise always wins, the first byte picks the command state
  always_comb begin
    next_state_s = state_r;
    if (ss_rise_s) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ss_fall_s) begin
            next_state_s = ST_CMD;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_CMD: begin
          if (byte_vld_r) begin
            case (byte_r)
              CMD_STATUS:  next_state_s = ST_STAT;
              CMD_MAC:     next_state_s = ST_MAC;
              CMD_TXREAD:  next_state_s = ST_TX;
              CMD_RXWRITE: next_state_s = ST_RX;
              default:     next_state_s = ST_SKIP;
            endcase
          end else begin
            next_state_s = ST_CMD;
          end
        end
        default: next_state_s = state_r;
      endcase
    end
  end

  // Strobe requests: TX prefetch at decode and after every TX byte, one per RX byte, first six MAC bytes
  always_comb begin
    req_s      = 1'b0;
    req_tgt_s  = TGT_NONE;
    req_byte_s = byte_r;
    if (decode_s && (byte_r == CMD_TXREAD)) begin
      req_s     = 1'b1;
      req_tgt_s = TGT_TX;
    end else if (payload_s) begin
      case (state_r)
        ST_TX: begin
          req_s     = 1'b1;
          req_tgt_s = TGT_TX;
        end
        ST_RX: begin
          req_s     = 1'b1;
          req_tgt_s = TGT_RX;
        end
        ST_MAC: begin
          if (mac_cnt_r < MAC_LEN) begin
            req_s     = 1'b1;
            req_tgt_s = TGT_MAC;
          end else begin
            req_s = 1'b0;
          end
        end
        default: req_s = 1'b0;
      endcase
    end else begin
      req_s = 1'b0;
    end
  end

  // Strobe start selection: the queued request goes first, a new one waits in the queue
  always_comb begin
    start_s      = 1'b0;
    start_tgt_s  = TGT_NONE;
    start_byte_s = 8'h00;
    if (sg_phase_r == SG_IDLE) begin
      if (pend_vld_r) begin
        start_s      = 1'b1;
        start_tgt_s  = pend_tgt_r;
        start_byte_s = pend_byte_r;
      end else if (req_s) begin
        start_s      = 1'b1;
        start_tgt_s  = req_tgt_s;
        start_byte_s = req_byte_s;
      end else begin
        start_s = 1'b0;
      end
    end else begin
      start_s = 1'b0;
    end
  end

  assign queue_s   = req_s && !((sg_phase_r == SG_IDLE) && !pend_vld_r);
  assign tx_load_s = (sg_phase_r == SG_HIGH) && (sg_cnt_r == PHASE_LAST) &&
                     (sg_tgt_r == TGT_TX) && (state_r == ST_TX);

  // One-deep queue for a request that arrives while a strobe cycle is running
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld_r  <= 1'b0;
      pend_tgt_r  <= TGT_NONE;
      pend_byte_r <= 8'h00;
    end else if (queue_s) begin
      pend_vld_r  <= 1'b1;
      pend_tgt_r  <= req_tgt_s;
      pend_byte_r <= req_byte_s;
    end else if (start_s && pend_vld_r) begin
      pend_vld_r <= 1'b0;
    end
  end

  // Strobe generator: setup cycle (data settles), STROBE_W high, STROBE_W low; never aborted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sg_phase_r   <= SG_IDLE;
      sg_cnt_r     <= 8'd0;
      sg_tgt_r     <= TGT_NONE;
      tx_strobe_r  <= 1'b0;
      rx_strobe_r  <= 1'b0;
      mac_strobe_r <= 1'b0;
    end else begin
      case (sg_phase_r)
        SG_IDLE: begin
          if (start_s) begin
            sg_phase_r <= SG_SETUP;
            sg_tgt_r   <= start_tgt_s;
          end
        end
        SG_SETUP: begin
          sg_phase_r   <= SG_HIGH;
          sg_cnt_r     <= 8'd0;
          tx_strobe_r  <= (sg_tgt_r == TGT_TX);
          rx_strobe_r  <= (sg_tgt_r == TGT_RX);
          mac_strobe_r <= (sg_tgt_r == TGT_MAC);
        end
        SG_HIGH: begin
          if (sg_cnt_r == PHASE_LAST) begin
            sg_phase_r   <= SG_LOW;
            sg_cnt_r     <= 8'd0;
            tx_strobe_r  <= 1'b0;
            rx_strobe_r  <= 1'b0;
            mac_strobe_r <= 1'b0;
          end else begin
            sg_cnt_r <= sg_cnt_r + 8'd1;
          end
        end
        SG_LOW: begin
          if (sg_cnt_r == PHASE_LAST) begin
            sg_phase_r <= SG_IDLE;
          end else begin
            sg_cnt_r <= sg_cnt_r + 8'd1;
          end
        end
        default: sg_phase_r <= SG_IDLE;
      endcase
    end
  end

  // Data bytes change only when their strobe cycle starts, so they hold through the low phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_byte_r  <= 8'h00;
      mac_byte_r <= 8'h00;
    end else if (start_s && (start_tgt_s == TGT_RX)) begin
      rx_byte_r <= start_byte_s;
    end else if (start_s && (start_tgt_s == TGT_MAC)) begin
      mac_byte_r <= start_byte_s;
    end
  end

  // MISO loads: status bytes at decode and after each payload byte, tx_byte at the end of the strobe high phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_r       <= 1'b0;
      load_data_r  <= 8'h00;
      status_lat_r <= 32'h0000_0000;
      stat_idx_r   <= 3'd0;
    end else begin
      load_r <= 1'b0;
      if (decode_s && (byte_r == CMD_STATUS)) begin
        load_r       <= 1'b1;
        load_data_r  <= status_byte(status, 3'd0);
        status_lat_r <= status;
        stat_idx_r   <= 3'd1;
      end else if (payload_s && (state_r == ST_STAT)) begin
        load_r      <= 1'b1;
        load_data_r <= status_byte(status_lat_r, stat_idx_r);
        if (stat_idx_r < 3'd4) begin
          stat_idx_r <= stat_idx_r + 3'd1;
        end
      end else if (tx_load_s) begin
        load_r      <= 1'b1;
        load_data_r <= tx_byte;
      end
    end
  end

  // Frame-level begin flags; tx/rx begin drop the clk after SS rise, mac_begin is a STROBE_W pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_begin_r  <= 1'b0;
      rx_begin_r  <= 1'b0;
      mac_begin_r <= 1'b0;
      mac_bcnt_r  <= 8'd0;
      mac_cnt_r   <= 3'd0;
    end else begin
      if (ss_rise_s) begin
        tx_begin_r <= 1'b0;
        rx_begin_r <= 1'b0;
      end else if (decode_s) begin
        tx_begin_r <= (byte_r == CMD_TXREAD);
        rx_begin_r <= (byte_r == CMD_RXWRITE);
      end
      if (decode_s && (byte_r == CMD_MAC)) begin
        mac_begin_r <= 1'b1;
        mac_bcnt_r  <= 8'd0;
        mac_cnt_r   <= 3'd0;
      end else begin
        if (mac_begin_r) begin
          if (mac_bcnt_r == PHASE_LAST) begin
            mac_begin_r <= 1'b0;
          end else begin
            mac_bcnt_r <= mac_bcnt_r + 8'd1;
          end
        end
        if (req_s && (req_tgt_s == TGT_MAC)) begin
          mac_cnt_r <= mac_cnt_r + 3'd1;
        end
      end
    end
  end

`ifdef ETH_SPI_BRIDGE_IRQ_EN
  logic irq_cond_s, irq_cond_r, eth_irq_r;
  assign irq_cond_s = (status[31:24] == ETH_STAT_TXPEND);

  // Interrupt on the first report of a pending TX frame; the TXREAD decode acknowledges it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_cond_r <= 1'b0;
      eth_irq_r  <= 1'b0;
    end else begin
      irq_cond_r <= irq_cond_s;
      if (decode_s && (byte_r == CMD_TXREAD)) begin
        eth_irq_r <= 1'b0;
      end else if (irq_cond_s && !irq_cond_r) begin
        eth_irq_r <= 1'b1;
      end
    end
  end

  assign eth_irq = eth_irq_r;
`endif

  assign tx_begin   = tx_begin_r;
  assign rx_begin   = rx_begin_r;
  assign mac_begin  = mac_begin_r;
  assign tx_strobe  = tx_strobe_r;
  assign rx_strobe  = rx_strobe_r;
  assign mac_strobe = mac_strobe_r;
  assign rx_byte    = rx_byte_r;
  assign mac_byte   = mac_byte_r;

endmodule
